// File: rtl/common_pkg.sv
// Shared constants and reader state type for the scan doubler.
package common_pkg;

    localparam int SCAN_MAX_PIXELS      = 1024;
    localparam int SCAN_HSYNC_OUT_WIDTH = 48;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        ACTIVE = 2'd2
    } scan_state_t;

endpackage

// File: rtl/line_ram.sv
// Two-bank 1-bit line store: one write port, one registered read port;
// the bank select is the address MSB.
module line_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          wr_en,
    input  logic [AW:0]   wr_addr,
    input  logic          wr_data,
    input  logic          rd_en,
    input  logic [AW:0]   rd_addr,
    output logic          rd_data
);

    logic mem [2*DEPTH];

    // Storage is deliberately unreset; the reader never shows it before a line is written.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/scan_doubler.sv
// Line doubler: stores each input line and replays it twice at 2x line rate.
// Build option SCAN_DOUBLER_SCANLINE_EN blanks the second pass (scanline effect).
module scan_doubler
    import common_pkg::*;
#(
    parameter int MAX_PIXELS      = SCAN_MAX_PIXELS,
    parameter int HSYNC_OUT_WIDTH = SCAN_HSYNC_OUT_WIDTH
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic pixel_en_i,
    input  logic out_pixel_en_i,
    input  logic video_i,
    input  logic h_sync_i,
    input  logic v_sync_i,
    output logic video_o,
    output logic h_sync_o,
    output logic v_sync_o,
    output logic overflow_o
);

    localparam int AW = $clog2(MAX_PIXELS);
    localparam int CW = $clog2(HSYNC_OUT_WIDTH + 1);
    localparam logic [AW:0]   FULL     = (AW+1)'(MAX_PIXELS);
    localparam logic [CW-1:0] SYNC_END = CW'(HSYNC_OUT_WIDTH - 1);

    logic          h_prev;
    logic          h_rise;
    logic          wr_en;
    logic [AW:0]   wr_addr;
    logic [AW:0]   line_len;
    logic          wr_bank;
    logic          rd_bank;
    logic          ram_q;

    scan_state_t   state, state_nxt;
    logic [CW-1:0] sync_cnt, sync_cnt_nxt;
    logic [AW:0]   rd_addr, rd_addr_nxt;
    logic          pass, pass_nxt;
    logic          show, show_nxt;
    logic          rd_en;

    assign h_rise = h_sync_i & ~h_prev;
    assign wr_en  = pixel_en_i & ~h_sync_i & (wr_addr != FULL);

    // Writer side; the edge register resets high so a held h_sync_i is not a new line.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            h_prev     <= 1'b1;
            wr_addr    <= '0;
            line_len   <= '0;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b1;
            overflow_o <= 1'b0;
        end else begin
            h_prev <= h_sync_i;
            if (h_rise) begin
                line_len <= wr_addr;
                wr_bank  <= ~wr_bank;
                rd_bank  <= wr_bank;
                wr_addr  <= '0;
            end else if (pixel_en_i && !h_sync_i) begin
                if (wr_addr == FULL) begin
                    overflow_o <= 1'b1;
                end else begin
                    wr_addr <= wr_addr + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state    <= IDLE;
            sync_cnt <= '0;
            rd_addr  <= '0;
            pass     <= 1'b0;
            show     <= 1'b0;
            v_sync_o <= 1'b0;
        end else begin
            state    <= state_nxt;
            sync_cnt <= sync_cnt_nxt;
            rd_addr  <= rd_addr_nxt;
            pass     <= pass_nxt;
            show     <= show_nxt;
            v_sync_o <= v_sync_i;
        end
    end

    // Reader: a line-end restart wins over any output enable on the same clock.
    always_comb begin
        state_nxt    = state;
        sync_cnt_nxt = sync_cnt;
        rd_addr_nxt  = rd_addr;
        pass_nxt     = pass;
        show_nxt     = show;
        rd_en        = 1'b0;
        if (h_rise) begin
            state_nxt    = SYNC;
            sync_cnt_nxt = '0;
            rd_addr_nxt  = '0;
            pass_nxt     = 1'b0;
            show_nxt     = 1'b0;
        end else if (out_pixel_en_i) begin
            case (state)
                IDLE: begin
                    show_nxt = 1'b0;
                end
                SYNC: begin
                    show_nxt = 1'b0;
                    if (sync_cnt == SYNC_END) begin
                        state_nxt    = ACTIVE;
                        sync_cnt_nxt = '0;
                    end else begin
                        sync_cnt_nxt = sync_cnt + 1'b1;
                    end
                end
                ACTIVE: begin
                    if (rd_addr == line_len) begin
                        show_nxt     = 1'b0;
                        sync_cnt_nxt = '0;
                        if (!pass) begin
                            pass_nxt    = 1'b1;
                            rd_addr_nxt = '0;
                            state_nxt   = SYNC;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        rd_en       = 1'b1;
                        rd_addr_nxt = rd_addr + 1'b1;
`ifdef SCAN_DOUBLER_SCANLINE_EN
                        show_nxt    = ~pass;
`else
                        show_nxt    = 1'b1;
`endif
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    show_nxt  = 1'b0;
                end
            endcase
        end
    end

    line_ram #(
        .DEPTH (MAX_PIXELS),
        .AW    (AW)
    ) u_line_ram (
        .clock   (clock_i),
        .wr_en   (wr_en),
        .wr_addr ({wr_bank, wr_addr[AW-1:0]}),
        .wr_data (video_i),
        .rd_en   (rd_en),
        .rd_addr ({rd_bank, rd_addr[AW-1:0]}),
        .rd_data (ram_q)
    );

    assign h_sync_o = (state == SYNC);
    assign video_o  = ram_q & show;

endmodule
